// File: rtl/iic_slv_ctrl.sv
// rtl/iic_slv_ctrl.sv - I2C target controller with register-file port and open-drain SDA.
// Optional 3-sample SCL/SDA majority filter: define IIC_SLV_GLITCH_FILTER_EN.
module iic_slv_ctrl #(
    parameter logic [6:0] SLV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       slv_busy,
    output logic       slv_stop
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic       scl_s, sda_s, scl_dly_q, scl_dly_d, sda_dly_q, sda_dly_d;
    logic       scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d, reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
    logic       rw_q, rw_d, reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d, cap_q, cap_d;
    logic       fall_q, fall_d, sda_oe_q, sda_oe_d, busy_q, busy_d, stop_q, stop_d;

    assign scl_sync_d = {scl_sync_q[0], scl_i};
    assign sda_sync_d = {sda_sync_q[0], sda_i};

`ifdef IIC_SLV_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic       scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;

    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
        sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
        scl_flt_d  = (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                     (scl_hist_q[0] & scl_hist_q[1]);
        sda_flt_d  = (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                     (sda_hist_q[0] & sda_hist_q[1]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_flt_q  <= scl_flt_d;
            sda_flt_q  <= sda_flt_d;
        end
    end

    assign scl_s = scl_flt_q;
    assign sda_s = sda_flt_q;
`else
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    assign scl_dly_d = scl_s;
    assign sda_dly_d = sda_s;
    assign scl_rise  = scl_s & ~scl_dly_q;
    assign scl_fall  = ~scl_s & scl_dly_q;
    assign start_ev  = scl_s & ~sda_s & sda_dly_q;
    assign stop_ev   = scl_s & sda_s & ~sda_dly_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rw_d        = rw_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        cap_d       = reg_rd_q;
        fall_d      = 1'b0;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        stop_d      = 1'b0;

        // Prefetched read byte lands one clk after reg_rd; pointer post-increments per byte read.
        if (cap_q) begin
            sh_d       = reg_rdata;
            reg_addr_d = reg_addr_q + 8'd1;
        end

        if (start_ev) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else if (stop_ev) begin
            state_d  = IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            stop_d   = busy_q;
            busy_d   = 1'b0;
        end else begin
            // SDA is updated one clk after the SCL fall, from the post-fall state.
            if (fall_q) begin
                case (state_q)
                    ADDR_ACK, REG_ACK, WDATA_ACK: sda_oe_d = 1'b1;
                    RDATA:                        sda_oe_d = ~sh_q[7];
                    default:                      sda_oe_d = 1'b0;
                endcase
            end

            if (scl_rise) begin
                case (state_q)
                    ADDR, REG, WDATA: begin
                        sh_d  = {sh_q[6:0], sda_s};
                        cnt_d = cnt_q + 4'd1;
                        if (state_q == REG && cnt_q == 4'd7) begin
                            reg_addr_d = {sh_q[6:0], sda_s};
                            state_d    = REG_ACK;
                            cnt_d      = 4'd0;
                        end else if (state_q == WDATA && cnt_q == 4'd7) begin
                            reg_wdata_d = {sh_q[6:0], sda_s};
                            reg_wr_d    = 1'b1;
                            state_d     = WDATA_ACK;
                            cnt_d       = 4'd0;
                        end
                    end
                    ADDR_ACK: begin
                        cnt_d    = 4'd1;
                        reg_rd_d = rw_q;
                    end
                    REG_ACK, WDATA_ACK: cnt_d = 4'd1;
                    RDATA:              cnt_d = cnt_q + 4'd1;
                    RACK: begin
                        cnt_d = 4'd0;
                        if (!sda_s) begin
                            reg_rd_d = 1'b1;
                            state_d  = RDATA;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            if (scl_fall) begin
                fall_d = 1'b1;
                case (state_q)
                    ADDR: if (cnt_q == 4'd8) begin
                        cnt_d = 4'd0;
                        if (sh_q[7:1] == SLV_ADDR) begin
                            state_d = ADDR_ACK;
                            rw_d    = sh_q[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                    ADDR_ACK: if (cnt_q == 4'd1) begin
                        state_d = rw_q ? RDATA : REG;
                        cnt_d   = 4'd0;
                    end
                    REG_ACK: if (cnt_q == 4'd1) begin
                        state_d = WDATA;
                        cnt_d   = 4'd0;
                    end
                    WDATA_ACK: if (cnt_q == 4'd1) begin
                        state_d    = WDATA;
                        cnt_d      = 4'd0;
                        reg_addr_d = reg_addr_q + 8'd1;
                    end
                    RDATA: begin
                        if (cnt_q == 4'd8) begin
                            state_d = RACK;
                            cnt_d   = 4'd0;
                        end else if (cnt_q != 4'd0) begin
                            sh_d = {sh_q[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
            scl_dly_q   <= 1'b1;
            sda_dly_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            sh_q        <= 8'h00;
            rw_q        <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            cap_q       <= 1'b0;
            fall_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_dly_q   <= scl_dly_d;
            sda_dly_q   <= sda_dly_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rw_q        <= rw_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            cap_q       <= cap_d;
            fall_q      <= fall_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            stop_q      <= stop_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign slv_busy  = busy_q;
    assign slv_stop  = stop_q;
endmodule

// File: tb/tb_iic_slv_ctrl.sv
// tb/tb_iic_slv_ctrl.sv - transaction-level model bench for iic_slv_ctrl.
module tb_iic_slv_ctrl;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_i, sda_i, sda_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr, reg_rd, slv_busy, slv_stop;

    int n_chk = 0, n_fail = 0;
    int ptr = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [15:0] wr_log[$];
    int  stop_cnt = 0, rd_cnt = 0;
    logic oe_seen = 1'b0, busy_seen = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;

    always #5 clk = ~clk;

    assign scl_i     = scl_m;
    assign sda_i     = sda_m & ~sda_oe;
    assign reg_rdata = reg_addr ^ 8'hFF;

    iic_slv_ctrl dut (
        .clk(clk), .rstn(rstn), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .slv_busy(slv_busy), .slv_stop(slv_stop)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (reg_wr) begin
                if (exp_wr.size() == 0) chk("unexpected reg_wr", {reg_addr, reg_wdata}, 32'hFFFF_FFFF);
                else chk("reg_wr addr/data", {reg_addr, reg_wdata}, exp_wr.pop_front());
                wr_log.push_back({reg_addr, reg_wdata});
            end
            if (reg_rd) begin
                rd_cnt++;
                if (exp_rd.size() == 0) chk("unexpected reg_rd", reg_addr, 32'hFFFF_FFFF);
                else chk("reg_rd addr", reg_addr, exp_rd.pop_front());
            end
            if (reg_wr && prev_wr) chk("reg_wr width", 2, 1);
            if (reg_rd && prev_rd) chk("reg_rd width", 2, 1);
            if (slv_stop) stop_cnt++;
            oe_seen   = oe_seen | sda_oe;
            busy_seen = busy_seen | slv_busy;
        end
        prev_wr = reg_wr;
        prev_rd = reg_rd;
    end

    task automatic wt(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wt(Q); scl_m = 1'b1; wt(Q);
        sda_m = 1'b0; wt(Q); scl_m = 1'b0; wt(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wt(Q); scl_m = 1'b1; wt(Q); sda_m = 1'b1; wt(2 * Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_m = b; wt(Q); scl_m = 1'b1;
        if (glitch) begin
            wt(Q); scl_m = 1'b0; wt(1); scl_m = 1'b1; wt(Q - 1);
        end else wt(2 * Q);
        scl_m = 1'b0; wt(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wt(Q); scl_m = 1'b1; wt(Q);
        b = sda_i; wt(Q); scl_m = 1'b0; wt(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, input logic ack_exp, input string name,
                              input int glitch_bit);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(v[i], i == glitch_bit);
        recv_bit(b);
        chk(name, !b, ack_exp);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic ack);
        for (int i = 7; i >= 0; i--) recv_bit(v[i]);
        send_bit(!ack, 1'b0);
    endtask

    task automatic model_write(input logic [7:0] dev, input logic [7:0] ra, input logic [7:0] d[]);
        if (dev[7:1] == 7'h50 && !dev[0]) begin
            ptr = ra;
            foreach (d[i]) begin
                exp_wr.push_back({ptr[7:0], d[i]});
                ptr = (ptr + 1) & 8'hFF;
            end
        end
    endtask

    task automatic do_write(input logic [7:0] dev, input logic [7:0] ra, input logic [7:0] d[],
                            input int glitch_bit);
        logic ok;
        ok = (dev[7:1] == 7'h50);
        model_write(dev, ra, d);
        bus_start();
        write_byte(dev, ok, "ack dev addr", -1);
        if (ok) begin
            write_byte(ra, 1'b1, "ack reg addr", -1);
            foreach (d[i]) write_byte(d[i], 1'b1, "ack wdata", (i == 0) ? glitch_bit : -1);
        end
        bus_stop();
    endtask

    logic [7:0] rb, ex;
    logic [7:0] dv[];

    initial begin
        wt(4);
        chk("rst sda_oe", sda_oe, 0);
        chk("rst reg_addr", reg_addr, 0);
        chk("rst reg_wdata", reg_wdata, 0);
        chk("rst reg_wr", reg_wr, 0);
        chk("rst reg_rd", reg_rd, 0);
        chk("rst slv_busy", slv_busy, 0);
        chk("rst slv_stop", slv_stop, 0);
        rstn = 1'b1;
        wt(8);

        // Two-byte write
        stop_cnt = 0;
        dv = '{8'h5A, 8'hC3};
        do_write(8'hA0, 8'h10, dv, -1);
        wt(4);
        chk("write stop pulses", stop_cnt, 1);
        chk("write log0", wr_log[0], 16'h105A);
        chk("write log1", wr_log[1], 16'h11C3);
        chk("write busy after stop", slv_busy, 0);

        // Combined read with repeated START
        ptr = 8'h20;
        bus_start();
        write_byte(8'hA0, 1'b1, "ack dev w", -1);
        write_byte(8'h20, 1'b1, "ack reg", -1);
        for (int i = 0; i < 3; i++) exp_rd.push_back(8'(ptr + i));
        rd_cnt = 0;
        bus_start();
        write_byte(8'hA1, 1'b1, "ack dev r", -1);
        chk("busy after Sr", slv_busy, 1);
        for (int i = 0; i < 3; i++) begin
            ex = ptr[7:0] ^ 8'hFF;
            ptr = (ptr + 1) & 8'hFF;
            read_byte(rb, i < 2);
            chk("read byte", rb, ex);
            if (i == 0) chk("read byte0 literal", rb, 8'hDF);
            if (i == 2) chk("read byte2 literal", rb, 8'hDD);
        end
        bus_stop();
        chk("read reg_rd count", rd_cnt, 3);
        chk("read final reg_addr", reg_addr, ptr);
        chk("read final reg_addr literal", reg_addr, 8'h23);

        // Wrong device address
        oe_seen = 1'b0; busy_seen = 1'b0; rd_cnt = 0;
        dv = '{8'h77};
        do_write(8'hA2, 8'h40, dv, -1);
        chk("wrong addr sda_oe seen", oe_seen, 0);
        chk("wrong addr busy seen", busy_seen, 0);
        chk("wrong addr wr count", wr_log.size(), 2);
        chk("wrong addr rd count", rd_cnt, 0);

        // Pointer wrap
        dv = '{8'h11, 8'h22};
        do_write(8'hA0, 8'hFF, dv, -1);
        wt(2);
        chk("wrap log2", wr_log[2], 16'hFF11);
        chk("wrap log3", wr_log[3], 16'h0022);

        // Abort by reset mid-read, then read from the reset pointer
        dv = new[0];
        do_write(8'hA0, 8'h10, dv, -1);
        exp_rd.push_back(ptr[7:0]);
        bus_start();
        write_byte(8'hA1, 1'b1, "ack abort dev", -1);
        for (int i = 0; i < 3; i++) recv_bit(rb[0]);
        sda_m = 1'b1; wt(Q); scl_m = 1'b1; wt(Q);
        chk("abort oe before reset", sda_oe, 1);
        rstn = 1'b0;
        #1;
        chk("abort oe on reset", sda_oe, 0);
        ptr = 0;
        wt(Q); scl_m = 1'b0; wt(Q);
        rstn = 1'b1; wt(Q);
        scl_m = 1'b1; wt(2 * Q);
        exp_rd.push_back(8'h00);
        bus_start();
        write_byte(8'hA1, 1'b1, "ack after abort", -1);
        read_byte(rb, 1'b0);
        chk("read after abort", rb, ptr[7:0] ^ 8'hFF);
        chk("read after abort literal", rb, 8'hFF);
        ptr = ptr + 1;
        bus_stop();

`ifdef IIC_SLV_GLITCH_FILTER_EN
        dv = '{8'h96};
        do_write(8'hA0, 8'h30, dv, 4);
        wt(2);
        chk("glitch filtered write", wr_log[wr_log.size() - 1], 16'h3096);
`endif

        wt(8);
        chk("pending writes", exp_wr.size(), 0);
        chk("pending reads", exp_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
